// File: rtl/usart_cmd_sched.sv
// Command scheduler: arbitrates config writes, queued TX bytes and RX reads onto the USART command bus.
// Strobes are registered (1 cycle after grant); TX backpressures via tx_ready, RX via rx_valid/rx_ready.

module usart_cmd_sched_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
endmodule

module usart_cmd_sched #(
  parameter int         TX_DEPTH   = 4,
  parameter int         TX_GAP     = 176,
  parameter int         RX_LAT     = 2,
  parameter logic [5:0] CTRL_RESET = 6'b000000
) (
  input  logic                        CPU_Clk,
  input  logic                        Reset,
  input  logic                        cfg_valid,
  input  logic [5:0]                  cfg_data,
  output logic                        cfg_ready,
  input  logic                        tx_valid,
  input  logic [7:0]                  tx_data,
  output logic                        tx_ready,
  input  logic                        rx_req,
  output logic                        rx_valid,
  output logic [7:0]                  rx_data,
  input  logic                        rx_ready,
  input  logic [7:0]                  usart_rx_data,
  output logic                        None,
  output logic                        Rec,
  output logic                        Trans,
  output logic [5:0]                  Control,
  output logic [7:0]                  CPU_Data_in,
  output logic                        busy,
  output logic [$clog2(TX_DEPTH):0]   tx_count
);
  localparam int CW    = $clog2(TX_DEPTH) + 1;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {IDLE, CFG, TX_CMD, TX_HOLD, RX_CMD, RX_WAIT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             grant_cfg, grant_tx, grant_rx, rx_sample;
  logic             rx_pending, last_tx, rx_elig, tx_elig;
  logic [7:0]       fifo_head;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign tx_ready  = (tx_count < CW'(TX_DEPTH));
  assign rx_elig   = rx_pending && !rx_valid;
  assign tx_elig   = (tx_count != '0);

  usart_cmd_sched_fifo #(.W(8), .DEPTH(TX_DEPTH), .CW(CW)) u_tx_fifo (
    .clk      (CPU_Clk),
    .rst      (Reset),
    .push     (tx_valid && tx_ready),
    .push_dat (tx_data),
    .pop      (grant_tx),
    .head_dat (fifo_head),
    .count    (tx_count)
  );

  // The gap counter spans the grant, TX_CMD and TX_HOLD plus the re-arbitration
  // cycle in IDLE, so back-to-back transmit strobes land exactly TX_GAP apart.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    grant_cfg = 1'b0;
    grant_tx  = 1'b0;
    grant_rx  = 1'b0;
    rx_sample = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          grant_cfg = 1'b1;
          state_n   = CFG;
        end else if (rx_elig && (!tx_elig || last_tx)) begin
          grant_rx = 1'b1;
          state_n  = RX_CMD;
        end else if (tx_elig) begin
          grant_tx = 1'b1;
          state_n  = TX_CMD;
          cnt_n    = CNT_W'(TX_GAP - 1);
        end
      end
      CFG: state_n = IDLE;
      TX_CMD: begin
        state_n = TX_HOLD;
        cnt_n   = cnt - CNT_W'(1);
      end
      TX_HOLD: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_n = IDLE;
      end
      RX_CMD: begin
        state_n = RX_WAIT;
        cnt_n   = CNT_W'(RX_LAT - 1);
      end
      RX_WAIT: begin
        if (cnt == '0) begin
          rx_sample = 1'b1;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CPU_Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      None        <= 1'b0;
      Rec         <= 1'b0;
      Trans       <= 1'b0;
      Control     <= CTRL_RESET;
      CPU_Data_in <= '0;
      rx_pending  <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      last_tx     <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      None  <= (state_n == CFG) || (state_n == TX_CMD) || (state_n == RX_CMD);
      Rec   <= (state_n == CFG) || (state_n == RX_CMD);
      Trans <= (state_n == CFG) || (state_n == TX_CMD);
      if (grant_cfg) Control <= cfg_data;
      if (grant_tx) CPU_Data_in <= fifo_head;
      if (grant_tx)      last_tx <= 1'b1;
      else if (grant_rx) last_tx <= 1'b0;
      // A request coinciding with the grant re-arms the pending flag.
      if (rx_req)        rx_pending <= 1'b1;
      else if (grant_rx) rx_pending <= 1'b0;
      if (rx_sample) begin
        rx_valid <= 1'b1;
        rx_data  <= usart_rx_data;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_usart_cmd_sched.sv
// Scoreboard bench for usart_cmd_sched: stimulus queues expected commands/bytes, a monitor checks them.
module tb_usart_cmd_sched;
  localparam int TX_DEPTH = 4;
  localparam int TX_GAP   = 176;
  localparam int RX_LAT   = 2;

  logic       CPU_Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       cfg_valid = 1'b0, tx_valid = 1'b0, rx_req = 1'b0, rx_ready = 1'b0;
  logic [5:0] cfg_data = '0;
  logic [7:0] tx_data = '0, usart_rx_data = '0;
  logic       cfg_ready, tx_ready, rx_valid, None, Rec, Trans, busy;
  logic [7:0] rx_data, CPU_Data_in;
  logic [5:0] Control;
  logic [2:0] tx_count;

  always #5 CPU_Clk = ~CPU_Clk;

  usart_cmd_sched #(.TX_DEPTH(TX_DEPTH), .TX_GAP(TX_GAP), .RX_LAT(RX_LAT), .CTRL_RESET(6'b000000)) dut (
    .CPU_Clk(CPU_Clk), .Reset(Reset),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .usart_rx_data(usart_rx_data),
    .None(None), .Rec(Rec), .Trans(Trans), .Control(Control), .CPU_Data_in(CPU_Data_in),
    .busy(busy), .tx_count(tx_count)
  );

  typedef struct packed {
    logic [2:0] cmd;
    logic [5:0] ctrl;
    logic [7:0] dat;
  } exp_t;

  exp_t       cmd_q[$];
  logic [7:0] rx_q[$];
  int         vectors = 0, miscompares = 0;
  int         cyc = 0, last_tx_cyc = -1, prev_tx_cyc = -1, rec_cyc = 0, rec_cnt = 0;
  bit         cfg_hold_mode = 1'b0, rx_seen = 1'b0;
  logic [5:0] cfg_hold_val = '0;
  logic [7:0] rx_held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: every command strobe and every newly presented RX byte is checked against the queues.
  always @(negedge CPU_Clk) begin : monitor
    exp_t e;
    cyc++;
    if (Reset) begin
      rx_seen = 1'b0;
    end else begin
      if ({None, Rec, Trans} != 3'b000) begin
        if ({None, Rec, Trans} == 3'b110) begin rec_cnt++; rec_cyc = cyc; end
        if ({None, Rec, Trans} == 3'b101) begin prev_tx_cyc = last_tx_cyc; last_tx_cyc = cyc; end
        if ({None, Rec, Trans} == 3'b111 && cfg_hold_mode) begin
          check("cfg_hold_ctrl", 32'(Control), 32'(cfg_hold_val));
        end else if (cmd_q.size() == 0) begin
          check("unexpected_cmd", 32'({None, Rec, Trans}), 32'(0));
        end else begin
          e = cmd_q.pop_front();
          check("cmd", 32'({None, Rec, Trans}), 32'(e.cmd));
          if (e.cmd == 3'b111) check("cfg_control", 32'(Control), 32'(e.ctrl));
          if (e.cmd == 3'b101) check("tx_byte", 32'(CPU_Data_in), 32'(e.dat));
        end
      end
      if (rx_valid) begin
        if (!rx_seen) begin
          check("rx_latency", 32'(cyc - rec_cyc), 32'(RX_LAT + 1));
          if (rx_q.size() == 0) check("unexpected_rx", 32'(rx_valid), 32'(0));
          else check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
          rx_held = rx_data;
        end else begin
          check("rx_hold", 32'(rx_data), 32'(rx_held));
        end
        rx_seen = !rx_ready;
      end else begin
        rx_seen = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CPU_Clk); #1; end
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while ((busy || tx_count != 0 || cmd_q.size() != 0 || rx_q.size() != 0) && i < 2000) begin
      tick();
      i++;
    end
    check({name, "_cmd_left"}, 32'(cmd_q.size()), 32'(0));
    check({name, "_rx_left"}, 32'(rx_q.size()), 32'(0));
  endtask

  task automatic cfg_write(input logic [5:0] d);
    int i;
    i = 0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    @(negedge CPU_Clk);
    while (!cfg_ready && i < 1000) begin @(negedge CPU_Clk); i++; end
    check("cfg_accept_timeout", 32'(cfg_ready), 32'(1));
    @(posedge CPU_Clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin : stim
    int i;
    // Reset state
    tick(2);
    check("rst_cmd", 32'({None, Rec, Trans}), 32'(0));
    check("rst_control", 32'(Control), 32'(0));
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_rx_valid", 32'(rx_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_tx_count", 32'(tx_count), 32'(0));
    Reset = 1'b0;
    tick();
    check("idle_cfg_ready", 32'(cfg_ready), 32'(1));

    // Config write: Setup strobe for exactly one cycle with the new Control
    cmd_q.push_back('{cmd: 3'b111, ctrl: 6'h2A, dat: 8'h00});
    cfg_write(6'h2A);
    check("cfg_busy", 32'(busy), 32'(1));
    check("cfg_strobe", 32'({None, Rec, Trans}), 32'(3'b111));
    check("cfg_value", 32'(Control), 32'(6'h2A));
    tick();
    check("cfg_busy_drop", 32'(busy), 32'(0));
    check("cfg_strobe_drop", 32'({None, Rec, Trans}), 32'(0));

    // Receive read, then backpressure while the byte is unread
    rx_ready      = 1'b0;
    usart_rx_data = 8'h3C;
    cmd_q.push_back('{cmd: 3'b110, ctrl: 6'h00, dat: 8'h00});
    rx_q.push_back(8'h3C);
    rx_req = 1'b1; tick(); rx_req = 1'b0;
    i = 0;
    while (!rx_valid && i < 20) begin tick(); i++; end
    check("rx_valid_set", 32'(rx_valid), 32'(1));
    check("rx_first_byte", 32'(rx_data), 32'(8'h3C));
    usart_rx_data = 8'h81;
    cmd_q.push_back('{cmd: 3'b110, ctrl: 6'h00, dat: 8'h00});
    rx_q.push_back(8'h81);
    rx_req = 1'b1; tick(); rx_req = 1'b0;
    tick(20);
    check("rx_bp_no_strobe", 32'(rec_cnt), 32'(1));
    check("rx_bp_idle", 32'(busy), 32'(0));
    check("rx_bp_valid", 32'(rx_valid), 32'(1));
    rx_ready = 1'b1;
    wait_drain("rx");
    check("rx_second_strobe", 32'(rec_cnt), 32'(2));

    // Two back-to-back TX bytes: strobes TX_GAP apart
    cmd_q.push_back('{cmd: 3'b101, ctrl: 6'h00, dat: 8'h55});
    cmd_q.push_back('{cmd: 3'b101, ctrl: 6'h00, dat: 8'hA3});
    push_byte(8'h55);
    push_byte(8'hA3);
    wait_drain("tx");
    check("tx_gap", 32'(last_tx_cyc - prev_tx_cyc), 32'(TX_GAP));

    // All three sources waiting in one IDLE cycle: CFG, then RX, then TX
    cmd_q.push_back('{cmd: 3'b101, ctrl: 6'h00, dat: 8'h11});
    push_byte(8'h11);
    tick(10);
    cmd_q.push_back('{cmd: 3'b111, ctrl: 6'h15, dat: 8'h00});
    cmd_q.push_back('{cmd: 3'b110, ctrl: 6'h00, dat: 8'h00});
    cmd_q.push_back('{cmd: 3'b101, ctrl: 6'h00, dat: 8'h22});
    usart_rx_data = 8'h5A;
    rx_q.push_back(8'h5A);
    rx_req = 1'b1;
    push_byte(8'h22);
    rx_req = 1'b0;
    check("hold_blocks_cfg", 32'(cfg_ready), 32'(0));
    cfg_write(6'h15);
    wait_drain("mixed");

    // FIFO full while config is held, then reset during TX_HOLD
    cfg_hold_val  = 6'h07;
    cfg_hold_mode = 1'b1;
    cfg_data      = 6'h07;
    cfg_valid     = 1'b1;
    tick(2);
    for (int k = 0; k < 5; k++) begin
      tx_valid = 1'b1;
      tx_data  = 8'hB0 + 8'(k);
      check("full_tx_ready", 32'(tx_ready), 32'(k < 4));
      tick();
    end
    tx_valid = 1'b0;
    check("full_count", 32'(tx_count), 32'(4));
    check("full_ready_low", 32'(tx_ready), 32'(0));
    cmd_q.push_back('{cmd: 3'b101, ctrl: 6'h00, dat: 8'hB0});
    cfg_valid = 1'b0;
    i = 0;
    while (cmd_q.size() != 0 && i < 20) begin tick(); i++; end
    tick(5);
    check("hold_busy", 32'(busy), 32'(1));
    check("hold_count", 32'(tx_count), 32'(3));
    Reset = 1'b1;
    #1;
    check("arst_cmd", 32'({None, Rec, Trans}), 32'(0));
    check("arst_count", 32'(tx_count), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_control", 32'(Control), 32'(0));
    check("arst_data", 32'(CPU_Data_in), 32'(0));
    tick();
    Reset = 1'b0;
    cfg_hold_mode = 1'b0;
    tick(3);
    check("post_rst_cmd", 32'({None, Rec, Trans}), 32'(0));
    check("post_rst_ready", 32'(tx_ready), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
